inv_subbytes_seq: RTL

Sequenced, area-reduced inverse SubBytes engine for the AES decryption datapath. It accepts one 128-bit state, plus an 8-bit XOR mask, through a valid/ready handshake. It then pushes the state through `LANES` shared `inv_sbox` instances over `16/LANES` cycles and presents the registered result through a second valid/ready handshake. It sits between the inverse ShiftRows stage and AddRoundKey, replacing the fully parallel 16-S-box stage where area matters.

---
 rtl/inv_subbytes_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: sequenced inverse SubBytes engine.
// The 128-bit state is pushed through LANES shared inv_sbox instances,
// one group of LANES bytes per cycle, over N = 16/LANES cycles.
// Optional feature macro: INV_SUBBYTES_SEQ_MASK_EN (captures in_mask and XORs
// it into every byte before inversion; when undefined in_mask is ignored).
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both sampled high. The producer holds valid and its
// data steady until that edge. in_ready is high only in IDLE. out_valid is
// high only in DONE, and out_data does not change while out_valid is high.

// Inverse AES S-box: inverse affine map followed by GF(2^8) inversion.
module inv_sbox (
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    logic [7:0] aff;
    logic [7:0] x2, x4, x8, x16, x32, x64, x128;

    // Undo the affine transform, then invert via x^254 = x^2*x^4*...*x^128.
    always_comb begin
        aff  = {in_byte_i[6:0], in_byte_i[7]}
             ^ {in_byte_i[4:0], in_byte_i[7:5]}
             ^ {in_byte_i[1:0], in_byte_i[7:2]}
             ^ 8'h05;
        x2   = gf_mul(aff, aff);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        out_byte_o = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                            gf_mul(gf_mul(x32, x64), x128));
    end

endmodule

module inv_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic [0:7]   in_mask,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    localparam int N  = 16 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Only divisors of 16 give an even split of the state into groups.
    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [0:127]    src_q, src_d;
    logic [0:127]    out_q, out_d;
    logic [0:7]      mask_v;
    logic [7:0]      lane_in  [LANES];
    logic [7:0]      lane_out [LANES];

`ifdef INV_SUBBYTES_SEQ_MASK_EN
    logic [0:7]      mask_q, mask_d;
    assign mask_v = mask_q;
`else
    // Mask port kept for a stable port list; its value never reaches logic.
    logic            unused_mask;
    assign unused_mask = ^in_mask;
    assign mask_v      = 8'h00;
`endif

    // Select the current group's source bytes and apply the mask.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = src_q[(int'(cnt_q) * LANES + l) * 8 +: 8] ^ mask_v;
        end
    end

    genvar gl;
    generate
        for (gl = 0; gl < LANES; gl++) begin : g_lane
            inv_sbox u_sbox (
                .in_byte_i  (lane_in[gl]),
                .out_byte_o (lane_out[gl])
            );
        end
    endgenerate

    // Next-state logic: capture in IDLE, one group per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        out_d   = out_q;
`ifdef INV_SUBBYTES_SEQ_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
`ifdef INV_SUBBYTES_SEQ_MASK_EN
                    mask_d  = in_mask;
`endif
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    out_d[(int'(cnt_q) * LANES + l) * 8 +: 8] = lane_out[l];
                end
                if (cnt_q == CW'(N - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset discards any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            out_q   <= '0;
`ifdef INV_SUBBYTES_SEQ_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            out_q   <= out_d;
`ifdef INV_SUBBYTES_SEQ_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_data  = out_q;

endmodule
